edge_sense: RTL
===============

# edge_sense

Front-end sense stage for the clock-recovery path. Synchronizes an asynchronous raw clock pin into the system domain, rejects glitches shorter than a programmable number of cycles, and emits a one-cycle `sense_event_o` on each qualified edge. `sense_event_o` drives `sense_event_i` of `half_rate_recovery`. `event_polarity_o` tells that block's polarity filter which level phase just ended.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; legal values are 2 or more.
- `FILTER_WIDTH`, default 4: width of the stability threshold and counter.

Ports:
- `sys_dom_i`, input, `common_p::clk_dom_s`: single clock `.clk` and clock enable `.clk_en`. Reset is `.sync_rst`, asynchronous and active-high; it sits in the sensitivity list of every flop. The field name is historical.
- `sense_en_i`, input, 1: enable. Low forces IDLE.
- `clear_state_i`, input, 1: restart acquisition and zero the glitch count.
- `raw_clk_i`, input, 1: asynchronous clock pin under observation.
- `min_stable_i`, input, `FILTER_WIDTH`: number of consecutive cycles a new level must hold before it is accepted. A value of 0 is treated as 1.
- `edge_select_i`, input, 2: edge selection, sampled each cycle. 00 = none, 01 = rising, 10 = falling, 11 = both.
- `sense_event_o`, output, 1: one-cycle qualified-edge pulse.
- `event_polarity_o`, output, 1: level of the phase that just ended. 1 means a falling edge (a high phase ended). Valid with `sense_event_o` and held until the next event.
- `filtered_level_o`, output, 1: debounced level.
- `glitch_count_o`, output, 8: rejected transitions, saturating at 255.

## Operation
- Synchronizer: `SYNC_STAGES` flops, all reset to 0. Its output is `sync_lvl`.
- FSM states: IDLE, ACQUIRE, STABLE, QUALIFY. Reset state is IDLE.
- IDLE:
  - No events are produced.
  - Moves to ACQUIRE when `sense_en_i` = 1.
- ACQUIRE:
  - `filtered_level` <= `sync_lvl`. No event is produced, so there is no false edge at startup.
  - Always moves to STABLE.
- STABLE, when `sync_lvl` != `filtered_level`:
  - If effective `min_stable` = 1, accept immediately and stay in STABLE.
  - Otherwise set `stable_cnt` <= 1 and move to QUALIFY.
- QUALIFY:
  - If `sync_lvl` == `filtered_level`, this is a glitch. `glitch_count` increments (saturating) and the FSM returns to STABLE with no event.
  - Otherwise `stable_cnt` increments. When `stable_cnt` + 1 == `min_stable_i`, accept and move to STABLE.
- Accept:
  - `filtered_level` toggles.
  - `event_polarity_o` <= old level.
  - `event_q` <= 1 only if the edge type is enabled in `edge_select_i`. Rising means old level 0; falling means old level 1.
  - `filtered_level` toggles even when the event is masked.
- `sense_en_i` = 0 in any state moves to IDLE at the next update. Pending qualification is dropped and no glitch is counted.
- `clear_state_i` = 1 while enabled:
  - Moves to ACQUIRE and zeroes `glitch_count` and `stable_cnt`.
  - Takes priority over accept and glitch in the same cycle; no event is produced.
  - While disabled, it only zeroes `glitch_count`.
- `min_stable_i` changing mid-QUALIFY takes effect on the next compare. If `stable_cnt` + 1 already exceeds the new value, accept on the next cycle.
- `stable_cnt` saturates and never wraps.

## Timing
- Reset values: `sense_event_o`, `event_polarity_o`, `filtered_level_o` and `glitch_count_o` are all 0; FSM is in IDLE.
- Every register updates only when `clk_en` = 1.
- `sense_event_o` = `event_q & clk_en`, so a pulse is seen exactly once. `event_q` clears on the next enabled cycle.
- Latency from a raw transition (ideal capture) to `sense_event_o` is `SYNC_STAGES` + max(`min_stable_i`, 1) enabled clock edges.
- Minimum accepted phase width is `min_stable_i` cycles. A phase of `min_stable_i` − 1 cycles is counted as a glitch.
- Back-to-back edges are allowed: with threshold 1, a level that toggles every cycle yields a pulse every cycle.
- Asynchronous reset mid-qualification clears everything immediately. After reset the FSM passes through ACQUIRE before it can detect any edge.

## Structure
- Add `edge_sel_e` (NONE, RISE, FALL, BOTH) and `GLITCH_CNT_WIDTH` = 8 to `clks_alot_p`.
- Sub-module `sync_chain` (parameter `SYNC_STAGES`, asynchronous reset) for reuse by other pin inputs.
- FSM, counters and event logic live in `edge_sense`.

## Test plan
- Enable with `raw_clk_i` held at 1, threshold 3: after ACQUIRE, `filtered_level_o` = 1 and no event is produced.
- Square wave with 10-cycle phases, `SYNC_STAGES` 2, threshold 3, both edges selected: a pulse 5 cycles after each raw edge. Polarity alternates; the first event after a rising raw edge has `event_polarity_o` = 0.
- 2-cycle high glitch with threshold 3: no event, `glitch_count_o` = 1, and `filtered_level_o` stays 0. After 300 glitches, `glitch_count_o` = 255.
- `edge_select_i` = 01 on a square wave: pulses on rising edges only, while `filtered_level_o` still tracks both edges.
- `clear_state_i` asserted in the cycle an accept is due: no pulse, `glitch_count_o` = 0, FSM re-acquires.
- Asynchronous reset during QUALIFY, then `clk_en` toggling at 50%: all outputs are 0 immediately after reset, and each pulse is seen once, with latency counted in enabled cycles.

Source files
------------

// File: rtl/clks_alot_p.sv
// -----------------------------------------------------------------------------
// clks_alot_p
// Types and constants for the clock-recovery front end.
//   GLITCH_CNT_WIDTH : width of the saturating rejected-transition counter
//   edge_sel_e       : edge selection encoding (bit 0 rising, bit 1 falling)
//   sense_state_e    : edge_sense FSM states
//   edge_enabled()   : whether an accepted edge leaving old_level is reported
// -----------------------------------------------------------------------------
package clks_alot_p;

    localparam int unsigned GLITCH_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StStable,
        StQualify
    } sense_state_e;

    // A rising edge leaves level 0, a falling edge leaves level 1.
    function automatic logic edge_enabled(input edge_sel_e sel, input logic old_level);
        logic en;
        case (sel)
            NONE:    en = 1'b0;
            RISE:    en = ~old_level;
            FALL:    en = old_level;
            BOTH:    en = 1'b1;
            default: en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/common_p.sv
// -----------------------------------------------------------------------------
// common_p
// Shared types used across clock-domain aware blocks.
//   clk_dom_s : bundles a clock, its clock enable and an asynchronous,
//               active-high reset. The reset field is named sync_rst for
//               historical reasons; it is asynchronous.
// -----------------------------------------------------------------------------
package common_p;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   i_clk    : destination clock
//   i_rst    : asynchronous active-high reset, clears every stage to 0
//   i_clk_en : clock enable, stages shift only when high
//   i_d      : asynchronous input
//   o_q      : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_en,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else if (i_clk_en) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/edge_sense.sv
// -----------------------------------------------------------------------------
// edge_sense
// Synchronizes a raw clock pin, rejects level phases shorter than a
// programmable threshold and emits a one-cycle pulse on each qualified edge.
// Ports:
//   sys_dom_i        : clock, clock enable and asynchronous active-high reset
//   sense_en_i       : enable; low parks the FSM in idle
//   clear_state_i    : restart acquisition and zero the glitch counter
//   raw_clk_i        : asynchronous pin under observation
//   min_stable_i     : cycles a new level must hold before acceptance (0 acts as 1)
//   edge_select_i    : which edges raise sense_event_o (see edge_sel_e)
//   sense_event_o    : one-cycle qualified-edge pulse
//   event_polarity_o : level of the phase that just ended (1 = falling edge)
//   filtered_level_o : debounced level
//   glitch_count_o   : rejected transitions, saturating
// -----------------------------------------------------------------------------
module edge_sense
    import clks_alot_p::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_WIDTH = 4
) (
    input  common_p::clk_dom_s            sys_dom_i,
    input  logic                          sense_en_i,
    input  logic                          clear_state_i,
    input  logic                          raw_clk_i,
    input  logic [FILTER_WIDTH-1:0]       min_stable_i,
    input  logic [1:0]                    edge_select_i,
    output logic                          sense_event_o,
    output logic                          event_polarity_o,
    output logic                          filtered_level_o,
    output logic [GLITCH_CNT_WIDTH-1:0]   glitch_count_o
);

    logic w_clk;
    logic w_clk_en;
    logic w_rst;
    logic w_sync_lvl;

    assign w_clk    = sys_dom_i.clk;
    assign w_clk_en = sys_dom_i.clk_en;
    assign w_rst    = sys_dom_i.sync_rst;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .i_clk    (w_clk),
        .i_rst    (w_rst),
        .i_clk_en (w_clk_en),
        .i_d      (raw_clk_i),
        .o_q      (w_sync_lvl)
    );

    sense_state_e                r_state;
    sense_state_e                w_state_nxt;
    logic                        r_filt;
    logic                        w_filt_nxt;
    logic                        r_pol;
    logic                        w_pol_nxt;
    logic                        r_event;
    logic                        w_event_nxt;
    logic [FILTER_WIDTH-1:0]     r_stable_cnt;
    logic [FILTER_WIDTH-1:0]     w_cnt_nxt;
    logic [GLITCH_CNT_WIDTH-1:0] r_glitch_cnt;
    logic [GLITCH_CNT_WIDTH-1:0] w_glitch_nxt;

    logic [FILTER_WIDTH-1:0]     w_min_eff;
    logic [FILTER_WIDTH:0]       w_cnt_inc;
    logic                        w_reach;
    logic                        w_diff;
    logic                        w_accept;

    assign w_min_eff = (min_stable_i == '0) ? FILTER_WIDTH'(1) : min_stable_i;
    // One extra bit so a saturated counter still compares correctly.
    assign w_cnt_inc = {1'b0, r_stable_cnt} + (FILTER_WIDTH + 1)'(1);
    // >= rather than == so a threshold lowered mid-qualification accepts at once.
    assign w_reach   = (w_cnt_inc >= {1'b0, w_min_eff});
    assign w_diff    = (w_sync_lvl != r_filt);

    always_comb begin
        w_state_nxt  = r_state;
        w_filt_nxt   = r_filt;
        w_pol_nxt    = r_pol;
        w_event_nxt  = 1'b0;
        w_cnt_nxt    = r_stable_cnt;
        w_glitch_nxt = r_glitch_cnt;
        w_accept     = 1'b0;

        if (!sense_en_i) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            if (clear_state_i) begin
                w_glitch_nxt = '0;
            end
        end else if (clear_state_i) begin
            // Clear outranks any accept or glitch due this cycle.
            w_state_nxt  = StAcquire;
            w_cnt_nxt    = '0;
            w_glitch_nxt = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_nxt = StAcquire;
                end
                StAcquire: begin
                    // Adopt the current level silently: no startup edge.
                    w_filt_nxt  = w_sync_lvl;
                    w_state_nxt = StStable;
                end
                StStable: begin
                    if (w_diff) begin
                        if (w_min_eff == FILTER_WIDTH'(1)) begin
                            w_accept = 1'b1;
                        end else begin
                            w_cnt_nxt   = FILTER_WIDTH'(1);
                            w_state_nxt = StQualify;
                        end
                    end
                end
                StQualify: begin
                    if (!w_diff) begin
                        if (r_glitch_cnt != '1) begin
                            w_glitch_nxt = r_glitch_cnt + GLITCH_CNT_WIDTH'(1);
                        end
                        w_state_nxt = StStable;
                    end else if (w_reach) begin
                        w_accept    = 1'b1;
                        w_state_nxt = StStable;
                    end else if (r_stable_cnt != '1) begin
                        w_cnt_nxt = r_stable_cnt + FILTER_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase

            // Level tracks every accepted edge; only the pulse is masked.
            if (w_accept) begin
                w_filt_nxt  = ~r_filt;
                w_pol_nxt   = r_filt;
                w_event_nxt = edge_enabled(edge_sel_e'(edge_select_i), r_filt);
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state      <= StIdle;
            r_filt       <= 1'b0;
            r_pol        <= 1'b0;
            r_event      <= 1'b0;
            r_stable_cnt <= '0;
            r_glitch_cnt <= '0;
        end else if (w_clk_en) begin
            r_state      <= w_state_nxt;
            r_filt       <= w_filt_nxt;
            r_pol        <= w_pol_nxt;
            r_event      <= w_event_nxt;
            r_stable_cnt <= w_cnt_nxt;
            r_glitch_cnt <= w_glitch_nxt;
        end
    end

    // Gate with the enable so a held event is consumed exactly once.
    assign sense_event_o    = r_event & w_clk_en;
    assign event_polarity_o = r_pol;
    assign filtered_level_o = r_filt;
    assign glitch_count_o   = r_glitch_cnt;

endmodule
